decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Decode stage, directly downstream of the fetch stage. Accepts the 68-bit instruction word over a valid/ready
//  handshake and splits it into opcode, addressing mode, register select and operand. Presents the registered
//  decoded result to the execute stage through a 2-deep skid buffer. Rejects illegal encodings and halts intake
//  until software clears the halt.
// PARAMETERS
//  INST_W    68    instruction width: [67:65] opcode, [64] mode, [63:32] reg/addr field, [31:0] operand
//  DATA_W    32    operand width
//  CNT_W     16    width of the decoded-instruction counter
//  REG_B_ID  'hB   reg field value that selects register B
//  REG_C_ID  'hC   reg field value that selects register C
// PORTS
//  clk           in   1       clock, all state updates on rising edge
//  rst           in   1       asynchronous, active-high reset
//  fetch_inst    in   INST_W  instruction word from the fetch stage
//  fetch_valid   in   1       fetch_inst is valid
//  fetch_ready   out  1       decode can accept this cycle
//  dec_valid     out  1       decoded fields valid
//  dec_ready     in   1       execute stage accepts the decoded fields
//  dec_opcode    out  3       000 ADD,001 SUB,010 MUL,011 DIV,100 LDA,101 STA,110 MOV
//  dec_addr_mode out  1       1 = address mode, 0 = data mode
//  dec_reg_sel   out  2       00 accumulator/none, 01 B, 10 C
//  dec_operand   out  DATA_W  fetch_inst[31:0]
//  dec_is_alu    out  1       opcode 000..011
//  dec_is_mem    out  1       opcode 100 or 101
//  halt_clear    in   1       single-cycle pulse: leave HALT
//  illegal       out  1       one-cycle pulse when an illegal word is consumed
//  halted        out  1       FSM is in HALT
//  dec_count     out  CNT_W   number of output handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async, rst=1): every output is 0 (fetch_ready=0 while rst is high), both buffer entries are empty,
//    FSM = RUN, dec_count = 0. After reset deasserts, fetch_ready=1 on the first clk edge.
//  - FSM states. RUN: accept input. HALT: fetch_ready=0. An illegal accept moves RUN->HALT.
//    halt_clear in HALT moves HALT->RUN on the next edge. halt_clear in RUN has no effect.
//  - fetch_ready = (state==RUN) & ~skid_full. This signal is registered-state only. It has no combinational
//    path from dec_ready.
//  - An accept occurs when fetch_valid & fetch_ready. Decode on the accepted word is combinational.
//    The result is registered.
//  - Illegal conditions: opcode 111; reg field not in {0, REG_B_ID, REG_C_ID}; MOV with reg field 0.
//    An illegal word is consumed and not stored. illegal pulses 1 cycle. HALT starts on the next cycle.
//    dec_count does not change.
//  - Entries already buffered before the illegal word still drain to execute while HALT is active.
//  - Buffering (OUT register + SKID register):
//    - When OUT is empty or dec_ready=1, OUT loads from SKID if SKID is full, otherwise from the accepted word.
//    - When OUT is full and dec_ready=0, the accepted word goes to SKID.
//    - SKID full => fetch_ready=0 on the next cycle.
//  - Latency: accept on edge N gives dec_valid=1 after edge N, i.e. one cycle when OUT is empty.
//  - Throughput: 1 per cycle with dec_ready held high.
//  - Ordering is strictly preserved. No word is duplicated or dropped, except illegal words.
//  - dec_valid stays high and all dec_* fields stay stable until dec_ready=1.
//  - dec_count increments on each dec_valid & dec_ready. It wraps from 2^CNT_W-1 to 0.
//  - Simultaneous output handshake and accept with SKID full: OUT<-SKID and SKID<-new word, so occupancy
//    stays at 2.
//  - rst asserted mid-transfer: all buffered words are discarded immediately. No partial output.
// TESTING
//  1. Stream 9_00000000_00000003, D_0000000B_00000004, 0_00000000_0000000B, B_00000000_00000005 with dec_ready=1
//     -> outputs in order:
//     (100,1,00,3); (110,1,01,4); (000,0,00,'hB); (101,1,00,5). dec_count=4. Latency 1 cycle.
//  2. dec_ready=0 while 3 words are offered -> 2 accepted, then fetch_ready=0. Fields are stable.
//     Release dec_ready -> all 3 arrive in order.
//  3. Word E_00000000_00000001 (opcode 111) -> illegal pulses 1 cycle, halted=1, fetch_ready=0,
//     no dec_valid for it. Earlier buffered word still drains. halt_clear -> fetch_ready=1 next cycle.
//  4. MOV with reg field 7 (D_00000007_00000004) and MOV with reg field 0 (D_00000000_00000004)
//     -> both are illegal, enter HALT.
//  5. Assert rst with 2 entries buffered -> dec_valid=0, fetch_ready=0, dec_count=0, all immediately.
//     Next word after release has latency 1.
//  6. CNT_W=4, 17 handshakes -> dec_count=1 (wrap). Back-to-back accept with occupancy 2 and dec_ready=1
//     -> no loss of words.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage
//   Decode stage that sits directly after fetch. A 68-bit instruction word arrives over a
//   valid/ready handshake. It is split into opcode, addressing mode, register select and
//   operand. The decoded result reaches the execute stage through an OUT register backed
//   by one SKID register. An illegal encoding is consumed and dropped, and intake then
//   halts until halt_clear is pulsed.
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   fetch_inst/valid/ready   upstream handshake (fetch_ready depends on state only)
//   dec_valid/ready          downstream handshake
//   dec_opcode/addr_mode/reg_sel/operand/is_alu/is_mem   decoded fields, held while stalled
//   halt_clear               pulse that leaves HALT
//   illegal                  one-cycle pulse when an illegal word is consumed
//   halted                   FSM is in HALT
//   dec_count                output handshakes, wraps modulo 2^CNT_W
module decode_stage #(
   parameter int unsigned INST_W   = 68,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned CNT_W    = 16,
   parameter logic [31:0] REG_B_ID = 32'hB,
   parameter logic [31:0] REG_C_ID = 32'hC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INST_W-1:0] fetch_inst,
   input  logic              fetch_valid,
   output logic              fetch_ready,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [2:0]        dec_opcode,
   output logic              dec_addr_mode,
   output logic [1:0]        dec_reg_sel,
   output logic [DATA_W-1:0] dec_operand,
   output logic              dec_is_alu,
   output logic              dec_is_mem,
   input  logic              halt_clear,
   output logic              illegal,
   output logic              halted,
   output logic [CNT_W-1:0]  dec_count
);

   localparam int unsigned REG_W = INST_W - 4 - DATA_W;

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   typedef struct packed {
      logic [2:0]        opcode;
      logic              addr_mode;
      logic [1:0]        reg_sel;
      logic [DATA_W-1:0] operand;
      logic              is_alu;
      logic              is_mem;
   } entry_t;

   // The register field must name a known register, opcode 111 is unused,
   // and MOV always needs an explicit register.
   function automatic logic word_legal(input logic [2:0] op, input logic [REG_W-1:0] rf);
      logic reg_ok;
      reg_ok = (rf == {REG_W{1'b0}}) || (rf == REG_W'(REG_B_ID)) || (rf == REG_W'(REG_C_ID));
      return (op != 3'b111) && reg_ok && !((op == 3'b110) && (rf == {REG_W{1'b0}}));
   endfunction

   function automatic logic [1:0] reg_sel_of(input logic [REG_W-1:0] rf);
      logic [1:0] sel;
      if (rf == REG_W'(REG_B_ID)) begin
         sel = 2'b01;
      end else if (rf == REG_W'(REG_C_ID)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   state_t           state_q, state_d;
   entry_t           out_q, out_d, skid_q, skid_d;
   logic             out_valid_q, out_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             fetch_ready_q, fetch_ready_d;

   logic [2:0]       inst_op_s;
   logic [REG_W-1:0] inst_reg_s;
   entry_t           new_entry_s;
   logic             accept_s, legal_s, acc_legal_s, acc_illegal_s;
   logic             out_fire_s, out_free_s;

   assign inst_op_s  = fetch_inst[INST_W-1 -: 3];
   assign inst_reg_s = fetch_inst[DATA_W +: REG_W];

   // Combinational decode of the word currently offered by fetch.
   always_comb begin
      new_entry_s           = '0;
      new_entry_s.opcode    = inst_op_s;
      new_entry_s.addr_mode = fetch_inst[INST_W-4];
      new_entry_s.reg_sel   = reg_sel_of(inst_reg_s);
      new_entry_s.operand   = fetch_inst[DATA_W-1:0];
      new_entry_s.is_alu    = ~inst_op_s[2];
      new_entry_s.is_mem    = (inst_op_s == 3'b100) || (inst_op_s == 3'b101);
   end

   assign legal_s       = word_legal(inst_op_s, inst_reg_s);
   assign accept_s      = fetch_valid & fetch_ready_q;
   assign acc_legal_s   = accept_s & legal_s;
   assign acc_illegal_s = accept_s & ~legal_s;
   assign out_fire_s    = out_valid_q & dec_ready;
   assign out_free_s    = ~out_valid_q | dec_ready;

   // Next-state logic of the RUN/HALT controller.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (acc_illegal_s) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            if (halt_clear) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_HALT;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // OUT/SKID steering: OUT refills from SKID first so ordering is kept.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (out_free_s) begin
         if (skid_valid_q) begin
            out_d       = skid_q;
            out_valid_d = 1'b1;
            if (acc_legal_s) begin
               skid_d       = new_entry_s;
               skid_valid_d = 1'b1;
            end else begin
               skid_valid_d = 1'b0;
            end
         end else if (acc_legal_s) begin
            out_d       = new_entry_s;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         if (acc_legal_s) begin
            skid_d       = new_entry_s;
            skid_valid_d = 1'b1;
         end else begin
            skid_valid_d = skid_valid_q;
         end
      end
   end

   // Counter, illegal pulse and ready. Ready is computed from next state so it is a
   // pure flop output with no path from dec_ready.
   always_comb begin
      if (out_fire_s) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
      illegal_d     = acc_illegal_s;
      fetch_ready_d = (state_d == ST_RUN) & ~skid_valid_d;
   end

   // Controller state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers; reset discards any buffered words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q         <= '0;
         out_valid_q   <= 1'b0;
         skid_q        <= '0;
         skid_valid_q  <= 1'b0;
         cnt_q         <= {CNT_W{1'b0}};
         illegal_q     <= 1'b0;
         fetch_ready_q <= 1'b0;
      end else begin
         out_q         <= out_d;
         out_valid_q   <= out_valid_d;
         skid_q        <= skid_d;
         skid_valid_q  <= skid_valid_d;
         cnt_q         <= cnt_d;
         illegal_q     <= illegal_d;
         fetch_ready_q <= fetch_ready_d;
      end
   end

   assign fetch_ready   = fetch_ready_q;
   assign dec_valid     = out_valid_q;
   assign dec_opcode    = out_q.opcode;
   assign dec_addr_mode = out_q.addr_mode;
   assign dec_reg_sel   = out_q.reg_sel;
   assign dec_operand   = out_q.operand;
   assign dec_is_alu    = out_q.is_alu;
   assign dec_is_mem    = out_q.is_mem;
   assign illegal       = illegal_q;
   assign halted        = (state_q == ST_HALT);
   assign dec_count     = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a scoreboard of expected decoded entries.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [67:0] fetch_inst;
   logic        fetch_valid;
   logic        fetch_ready;
   logic        dec_valid;
   logic        dec_ready;
   logic [2:0]  dec_opcode;
   logic        dec_addr_mode;
   logic [1:0]  dec_reg_sel;
   logic [31:0] dec_operand;
   logic        dec_is_alu;
   logic        dec_is_mem;
   logic        halt_clear;
   logic        illegal;
   logic        halted;
   logic [3:0]  dec_count;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          exp_count = 0;
   logic [39:0] sb[$];
   logic [39:0] mon_obs;
   longint      t0;

   decode_stage #(.CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .fetch_inst(fetch_inst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_opcode(dec_opcode), .dec_addr_mode(dec_addr_mode), .dec_reg_sel(dec_reg_sel),
      .dec_operand(dec_operand), .dec_is_alu(dec_is_alu), .dec_is_mem(dec_is_mem),
      .halt_clear(halt_clear), .illegal(illegal), .halted(halted), .dec_count(dec_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic m_legal(input logic [67:0] w);
      logic [2:0]  op;
      logic [31:0] rf;
      op = w[67:65];
      rf = w[63:32];
      if (op == 3'd7) return 1'b0;
      if (!(rf == 32'h0 || rf == 32'hB || rf == 32'hC)) return 1'b0;
      if (op == 3'd6 && rf == 32'h0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [39:0] m_decode(input logic [67:0] w);
      logic [2:0]  op;
      logic [1:0]  sel;
      op  = w[67:65];
      sel = (w[63:32] == 32'hB) ? 2'b01 : (w[63:32] == 32'hC) ? 2'b10 : 2'b00;
      return {op, w[64], sel, w[31:0], (op <= 3'd3), (op == 3'd4 || op == 3'd5)};
   endfunction

   function automatic logic [67:0] mk(input logic [2:0] op, input logic md,
                                      input logic [31:0] rf, input logic [31:0] opd);
      return {op, md, rf, opd};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offer one word, wait (bounded) for ready, record the expectation at the accept edge.
   task automatic send(input logic [67:0] w);
      int n;
      n = 0;
      fetch_inst  = w;
      fetch_valid = 1'b1;
      @(negedge clk);
      while (fetch_ready !== 1'b1 && n < 60) begin
         n++;
         @(negedge clk);
      end
      chk("accept_wait", 32'(fetch_ready), 32'd1);
      @(posedge clk);
      if (m_legal(w)) sb.push_back(m_decode(w));
      #1;
      fetch_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((sb.size() != 0 || dec_valid === 1'b1) && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: every valid cycle must present the scoreboard head; pop on handshake.
   always @(negedge clk) begin
      if (rst === 1'b0 && dec_valid === 1'b1) begin
         mon_obs = {dec_opcode, dec_addr_mode, dec_reg_sel, dec_operand, dec_is_alu, dec_is_mem};
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL unexpected_output observed=%h expected=none", mon_obs);
         end else begin
            n_cmp++;
            assert (mon_obs === sb[0]) else begin
               n_bad++;
               $error("FAIL dec_fields observed=%h expected=%h", mon_obs, sb[0]);
            end
            if (dec_ready === 1'b1) begin
               void'(sb.pop_front());
               exp_count++;
            end
         end
      end
   end

   initial begin
      rst = 1'b1; fetch_inst = 68'h0; fetch_valid = 1'b0; dec_ready = 1'b0; halt_clear = 1'b0;
      #2;
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
      chk("rst_count", 32'(dec_count), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_reset", 32'(fetch_ready), 32'd1);

      // 1: stream with dec_ready high, latency and throughput
      dec_ready = 1'b1;
      send(68'h9_00000000_00000003);
      @(negedge clk);
      chk("latency1", 32'(dec_valid), 32'd1);
      @(posedge clk); #1;
      t0 = $time;
      send(68'hD_0000000B_00000004);
      send(68'h0_00000000_0000000B);
      send(68'hB_00000000_00000005);
      chk("throughput", 32'($time - t0), 32'd30);
      drain();
      chk("count_after_t1", 32'(dec_count), 32'd4);

      // 2: stall, skid fills, ready drops, release drains in order
      dec_ready = 1'b0;
      send(68'h8_00000000_00000011);
      send(68'h2_0000000C_00000022);
      fetch_inst = 68'h4_0000000B_00000033;
      fetch_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("skid_full_ready", 32'(fetch_ready), 32'd0);
      @(posedge clk); #1;
      dec_ready = 1'b1;
      send(68'h4_0000000B_00000033);
      drain();
      chk("count_after_t2", 32'(dec_count), 32'd7);

      // 3: illegal opcode while a word is buffered
      dec_ready = 1'b0;
      send(68'h6_0000000B_00000044);
      send(68'hE_00000000_00000001);
      chk("illegal_pulse", 32'(illegal), 32'd1);
      chk("halted_set", 32'(halted), 32'd1);
      chk("halt_ready", 32'(fetch_ready), 32'd0);
      @(posedge clk); #1;
      chk("illegal_one_cycle", 32'(illegal), 32'd0);
      dec_ready = 1'b1;
      drain();
      chk("halted_while_drain", 32'(halted), 32'd1);
      chk("count_after_t3", 32'(dec_count), 32'(exp_count % 16));
      halt_clear = 1'b1;
      @(posedge clk); #1;
      halt_clear = 1'b0;
      chk("clear_ready", 32'(fetch_ready), 32'd1);
      chk("clear_halted", 32'(halted), 32'd0);
      halt_clear = 1'b1;
      @(posedge clk); #1;
      halt_clear = 1'b0;
      chk("clear_in_run", 32'(halted), 32'd0);

      // 4: MOV with bad register field and with no register field
      send(68'hD_00000007_00000004);
      chk("mov_r7_illegal", 32'(illegal), 32'd1);
      chk("mov_r7_halted", 32'(halted), 32'd1);
      halt_clear = 1'b1;
      @(posedge clk); #1;
      halt_clear = 1'b0;
      send(68'hD_00000000_00000004);
      chk("mov_r0_illegal", 32'(illegal), 32'd1);
      chk("mov_r0_halted", 32'(halted), 32'd1);
      halt_clear = 1'b1;
      @(posedge clk); #1;
      halt_clear = 1'b0;
      drain();

      // 5: reset with two words buffered
      dec_ready = 1'b0;
      send(68'h0_0000000C_00000055);
      send(68'hA_0000000B_00000066);
      @(posedge clk); #1;
      rst = 1'b1;
      sb.delete();
      exp_count = 0;
      #1;
      chk("midrst_dec_valid", 32'(dec_valid), 32'd0);
      chk("midrst_ready", 32'(fetch_ready), 32'd0);
      chk("midrst_count", 32'(dec_count), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      dec_ready = 1'b1;
      send(68'h2_00000000_00000077);
      @(negedge clk);
      chk("latency_after_rst", 32'(dec_valid), 32'd1);
      drain();

      // 6: counter wrap (17 handshakes since reset) then full-occupancy back-to-back
      for (int i = 0; i < 16; i++) begin
         logic [2:0]  op;
         logic [31:0] rf;
         op = 3'(i % 7);
         rf = (i % 3 == 0) ? 32'h0 : (i % 3 == 1) ? 32'hB : 32'hC;
         if (op == 3'd6 && rf == 32'h0) rf = 32'hC;
         send(mk(op, 1'(i), rf, 32'h1000 + 32'(i)));
      end
      drain();
      chk("count_wrap", 32'(dec_count), 32'd1);
      dec_ready = 1'b0;
      send(mk(3'd1, 1'b0, 32'hB, 32'hA1));
      send(mk(3'd2, 1'b1, 32'hC, 32'hA2));
      dec_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(mk(3'(i + 3), 1'(i), 32'hB, 32'hB0 + 32'(i)));
      end
      drain();
      chk("count_final", 32'(dec_count), 32'(exp_count % 16));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
